// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Holds the FSM state encoding and the pattern-length mask function.
package seq_det_pkg;

    localparam int unsigned MASK_W = 32;

    typedef enum logic [1:0] {
        S_UNCFG,
        S_FILL,
        S_HUNT
    } seq_state_t;

    // Low 'len' bits set; callers truncate to their pattern width.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        if (len >= MASK_W) begin
            return '1;
        end
        return (MASK_W'(1) << len) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter used for the optional match count.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count enabled events, stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with registered match pulse.
// Define SEQ_MATCH_CNT_EN to build the saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               match,
    output logic               armed,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

    seq_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [LEN_W-1:0]   cfg_len_c;
    logic [MAX_LEN-1:0] mask;
    logic               hit;

    // Shift/compare datapath and next-state selection.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;

        cfg_len_c = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        hist_n    = {hist_q, in_bit};
        fill_n    = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
        mask      = MAX_LEN'(len_mask(32'(len_q)));
        hit       = (fill_n >= len_q) &&
                    ((hist_n & mask) == (pat_q & mask));

        if (cfg_we) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len_c;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = (cfg_len_c >= LEN_MIN) ? S_FILL : S_UNCFG;
        end else if (in_valid && (state_q != S_UNCFG)) begin
            hist_d  = hist_n[MAX_LEN-2:0];
            fill_d  = fill_n;
            match_d = hit;
            state_d = (fill_n >= len_q) ? S_HUNT : S_FILL;
            if (hit && !ovl_q) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = S_FILL;
            end
        end
    end

    // Configuration, history and state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;
    assign armed = (state_q != S_UNCFG);

`ifdef SEQ_MATCH_CNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (match_q),
        .clr   (1'b0),
        .count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: vector table, directed
// corner cases and random traffic against a queue-based reference.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef SEQ_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       v;
        logic       b;
        logic       em;
        logic       ea;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic [7:0]       cfg_pattern = '0;
    logic [3:0]       cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             match;
    logic             armed;
    logic [CNT_W-1:0] match_count;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    bit   m_armed = 0;
    int   m_len = 0;
    logic [7:0] m_pat = '0;
    bit   m_ovl = 0;
    bit   q[$];
    bit   m_match = 0;
    int   m_count = 0;

    int   pulses;
    vec_t tbl[11];

    seq_detector_prog #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .match      (match),
        .armed      (armed),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [7:0] pat,
                                input logic [3:0] len, input logic ovl,
                                input logic v, input logic b,
                                input logic em, input logic ea);
        vec_t r;
        r.we = we; r.pat = pat; r.len = len; r.ovl = ovl;
        r.v = v; r.b = b; r.em = em; r.ea = ea;
        return r;
    endfunction

    // Behavioural reference: remembers accepted bits since the last
    // (re)start and matches on the most recent len of them.
    task automatic model(input vec_t s);
        bit prev;
        bit hit;
        int l;
        prev = m_match;
        if (s.we) begin
            l = (int'(s.len) > MAX_LEN) ? MAX_LEN : int'(s.len);
            m_len = l;
            m_pat = s.pat;
            m_ovl = s.ovl;
            m_armed = (l >= 2);
            q.delete();
            m_match = 0;
        end else if (s.v && m_armed) begin
            q.push_back(s.b);
            if (q.size() > MAX_LEN) void'(q.pop_front());
            hit = 0;
            if (q.size() >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
            end
            m_match = hit;
            if (hit && !m_ovl) q.delete();
        end else begin
            m_match = 0;
        end
        if (prev && m_count < CMAX) m_count++;
    endtask

    task automatic step(input vec_t s);
        @(negedge clk);
        cfg_we = s.we;
        cfg_pattern = s.pat;
        cfg_len = s.len;
        cfg_overlap = s.ovl;
        in_valid = s.v;
        in_bit = s.b;
        @(posedge clk);
        #1;
        model(s);
        chk("match", int'(match), int'(m_match));
        chk("armed", int'(armed), int'(m_armed));
        chk("count", int'(match_count), CNT_ON ? m_count : 0);
        if (match) pulses++;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                       input logic o);
        step(mk(1, p, l, o, 0, 0, 0, 0));
    endtask

    task automatic bitin(input logic v, input logic b);
        step(mk(0, 0, 0, 0, v, b, 0, 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_match", int'(match), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_count", int'(match_count), 0);
        m_armed = 0; q.delete(); m_match = 0; m_count = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t s;
        int c;
        logic [7:0] rp;

        tbl[0] = mk(1, 8'b010101, 4'd6, 1, 0, 0, 0, 1);
        for (int i = 1; i <= 10; i++)
            tbl[i] = mk(0, 0, 0, 0, 1, logic'((i - 1) % 2),
                        logic'(i == 6 || i == 8 || i == 10), 1);

        #1 reset = 1'b1;
        #1;
        chk("init_match", int'(match), 0);
        chk("init_armed", int'(armed), 0);
        chk("init_count", int'(match_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // overlap, table driven
        for (int i = 0; i < 11; i++) begin
            step(tbl[i]);
            chk("tbl_match", int'(match), int'(tbl[i].em));
            chk("tbl_armed", int'(armed), int'(tbl[i].ea));
        end
        bitin(0, 0);
        chk("ovl_count", int'(match_count), CNT_ON ? 3 : 0);

        // non-overlap
        cfg(8'b010101, 4'd6, 0);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            bitin(1, logic'((i - 1) % 2));
            if (i == 6 || i == 12) chk("novl_hit", int'(match), 1);
            if (i == 8 || i == 10) chk("novl_nohit", int'(match), 0);
        end
        chk("novl_pulses", pulses, 2);

        // gaps between bits
        cfg(8'b010101, 4'd6, 1);
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            bitin(1, logic'((i - 1) % 2));
            for (int g = 0; g < 3; g++) begin
                bitin(0, 1);
                chk("gap_low", int'(match), 0);
            end
        end
        chk("gap_pulses", pulses, 3);

        // reconfig with same-cycle valid bit
        bitin(1, 1); bitin(1, 0); bitin(1, 1);
        step(mk(1, 8'b110, 4'd3, 1, 1, 1, 0, 0));
        chk("rcfg_armed", int'(armed), 1);
        bitin(1, 1);
        bitin(1, 0);
        chk("rcfg_drop", int'(match), 0);
        bitin(1, 1); bitin(1, 1); bitin(1, 0);
        chk("rcfg_hit", int'(match), 1);

        // len 0 / 1 never arm
        cfg(8'h00, 4'd0, 1);
        chk("len0_armed", int'(armed), 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) bitin(1, 1'($urandom));
        cfg(8'h01, 4'd1, 1);
        for (int i = 0; i < 10; i++) bitin(1, 1);
        chk("len01_pulses", pulses, 0);

        // len above MAX_LEN clamps
        cfg(8'hA5, 4'd12, 0);
        rp = 8'hA5;
        for (int i = 7; i >= 0; i--) bitin(1, rp[i]);
        chk("clamp_hit", int'(match), 1);

        // reset mid-stream
        cfg(8'b010101, 4'd6, 1);
        bitin(1, 0); bitin(1, 1); bitin(1, 0); bitin(1, 1); bitin(1, 0);
        do_reset();
        bitin(1, 1);
        chk("post_rst_match", int'(match), 0);
        chk("post_rst_armed", int'(armed), 0);

        // saturation
        cfg(8'b11, 4'd2, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) bitin(1, 1);
        chk("sat_pulses", pulses, 5);
        bitin(0, 0);
        chk("sat_count5", int'(match_count), CNT_ON ? 5 : 0);
        for (int i = 0; i < 270; i++) bitin(1, 1);
        bitin(0, 0);
        bitin(0, 0);
        chk("sat_hold", int'(match_count), CNT_ON ? CMAX : 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            c = int'($urandom_range(0, 99));
            if (c < 3) begin
                s = mk(1, 8'($urandom), 4'($urandom_range(0, 10)),
                       1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
            end else begin
                s = mk(0, 8'($urandom), 4'($urandom), 1'($urandom),
                       logic'(c < 75), 1'($urandom), 0, 0);
            end
            step(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
